// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared fixed-point types, saturation limits and clamp helpers
package fc_pkg;

    typedef logic signed [31:0] acc_t;
    typedef logic signed [7:0]  act_t;

    localparam acc_t INT32_MAX = 32'sh7FFF_FFFF;
    localparam acc_t INT32_MIN = 32'sh8000_0000;
    localparam act_t INT8_MAX  = 8'sh7F;
    localparam act_t INT8_MIN  = 8'sh80;

    function automatic acc_t sat_int32(input logic signed [32:0] v);
        if (v > 33'sh0_7FFF_FFFF)
            return INT32_MAX;
        if (v < 33'sh1_8000_0000)
            return INT32_MIN;
        return acc_t'(v[31:0]);
    endfunction

    function automatic act_t sat_int8(input logic signed [48:0] v);
        if (v > 49'sd127)
            return INT8_MAX;
        if (v < -49'sd128)
            return INT8_MIN;
        return act_t'(v[7:0]);
    endfunction

endpackage

// File: rtl/fc_requant_if.sv
// rtl/fc_requant_if.sv - accumulator-in / activation-out stream bundle
// Ports: in_valid/in_sum/in_ready (sum stream), out_valid/out_data/out_last/out_ready (int8 stream).
// slave = requant block side, master = producer/consumer side.
interface fc_requant_if;
    import fc_pkg::*;

    logic in_valid;
    acc_t in_sum;
    logic in_ready;
    logic out_valid;
    act_t out_data;
    logic out_last;
    logic out_ready;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fc_out_fifo.sv
// rtl/fc_out_fifo.sv - synchronous output buffer with full/empty/count
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en/rd_data (head, combinational),
// full, empty, count. DEPTH must be a power of two.
module fc_out_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A write into a full buffer is legal when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fc_requant.sv
// rtl/fc_requant.sv - FC layer bias add, requant scale/shift, ReLU and int8 saturation
// Ports: clk, rst (sync, active-high), bus (fc_requant_if.slave: sum in, int8 out),
// bias_we/bias_addr/bias_data (bias table write), scale, shift, relu_en (per-layer static).
// Option: define FC_REQUANT_ROUND_EN for round-half-up before the right shift.
module fc_requant
    import fc_pkg::*;
#(
    parameter int NUM_NEURONS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    fc_requant_if.slave                    bus,
    input  logic                           bias_we,
    input  logic [$clog2(NUM_NEURONS)-1:0] bias_addr,
    input  acc_t                           bias_data,
    input  logic [15:0]                    scale,
    input  logic [4:0]                     shift,
    input  logic                           relu_en
);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    acc_t        bias_mem [NUM_NEURONS];
    logic [NW-1:0] neuron;
    logic        accept;

    logic                s1_valid, s1_last;
    acc_t                s1_sum;
    logic                s2_valid, s2_last;
    logic signed [47:0]  s2_prod;
    logic                s3_valid, s3_last;
    act_t                s3_act;

    logic signed [32:0]  sum33;
    logic signed [47:0]  prod;
    logic [48:0]         rnd;
    logic signed [48:0]  pre;
    logic signed [48:0]  shifted;
    logic signed [48:0]  clipped;

    logic [8:0]          head;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [OW-1:0]       occupancy;

    // Table is never reset; a write lands at the edge, so a sample accepted
    // in the same cycle still reads the previous value.
    always_ff @(posedge clk) begin
        if (bias_we)
            bias_mem[bias_addr] <= bias_data;
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign sum33  = {bus.in_sum[31], bus.in_sum} + {bias_mem[neuron][31], bias_mem[neuron]};
    assign prod   = 48'(s1_sum) * 48'(signed'({1'b0, scale}));

    always_comb begin
        rnd = '0;
`ifdef FC_REQUANT_ROUND_EN
        if (shift != 5'd0)
            rnd[shift - 5'd1] = 1'b1;
`endif
        pre     = 49'(s2_prod) + signed'(rnd);
        shifted = pre >>> shift;
        if (relu_en && shifted[48])
            clipped = '0;
        else
            clipped = shifted;
    end

    // Data registers advance every cycle; only the valid bits need reset.
    always_ff @(posedge clk) begin
        s1_sum  <= sat_int32(sum33);
        s1_last <= (neuron == NW'(NUM_NEURONS - 1));
        s2_prod <= prod;
        s2_last <= s1_last;
        s3_act  <= sat_int8(clipped);
        s3_last <= s2_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            neuron   <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (accept)
                neuron <= (neuron == NW'(NUM_NEURONS - 1)) ? '0 : neuron + NW'(1);
        end
    end

    fc_out_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s3_valid),
        .wr_data ({s3_last, s3_act}),
        .rd_en   (bus.out_valid && bus.out_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Every sample in flight has a reserved buffer slot, so the stages never stall.
    assign occupancy = OW'(fifo_count) + OW'(s1_valid) + OW'(s2_valid) + OW'(s3_valid);

    assign bus.in_ready  = !rst && !fifo_full && (occupancy < OW'(FIFO_DEPTH));
    assign bus.out_valid = !rst && !fifo_empty;
    assign bus.out_data  = bus.out_valid ? act_t'(head[7:0]) : '0;
    assign bus.out_last  = bus.out_valid ? head[8] : 1'b0;
endmodule

// File: tb/tb_fc_requant.sv
// tb/tb_fc_requant.sv - self-checking bench for fc_requant (NUM_NEURONS=4, FIFO_DEPTH=4)
module tb_fc_requant;
    logic               clk = 1'b0;
    logic               rst;
    logic               bias_we;
    logic [1:0]         bias_addr;
    logic signed [31:0] bias_data;
    logic [15:0]        scale;
    logic [4:0]         shift;
    logic               relu_en;

    fc_requant_if bus ();

    fc_requant #(.NUM_NEURONS(4), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bias_we   (bias_we),
        .bias_addr (bias_addr),
        .bias_data (bias_data),
        .scale     (scale),
        .shift     (shift),
        .relu_en   (relu_en)
    );

    always #5 clk = ~clk;

    typedef struct { longint d; bit l; } exp_t;
    typedef struct { int bias; int in_sum; int scl; int sh; bit relu; bit same; int exp; } vec_t;

    exp_t               q[$];
    longint             rd_log[$];
    int                 last_pos[$];
    logic signed [31:0] bias_m [4];
    int                 cnt_m = 0;
    int                 n_acc = 0;
    int                 n_rd  = 0;
    int                 n_checks = 0;
    int                 n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, floor division for the shift.
    function automatic longint ref_out(longint x, longint b, longint sc, int sh, bit relu);
        longint s, p, d, r;
        s = x + b;
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        p = s * sc;
`ifdef FC_REQUANT_ROUND_EN
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
        d = longint'(1) << sh;
        r = p / d;
        if ((p % d != 0) && (p < 0)) r = r - 1;
        if (relu && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic cycle();
        bit   acc, rd;
        exp_t e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        rd  = bus.out_valid && bus.out_ready;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                check("out_data", longint'(bus.out_data), q[0].d);
                check("out_last", longint'(bus.out_last), longint'(q[0].l));
            end
        end
        if (rd) begin
            n_rd++;
            rd_log.push_back(longint'(bus.out_data));
            if (bus.out_last) last_pos.push_back(n_rd);
            if (q.size() > 0) void'(q.pop_front());
        end
        if (acc) begin
            e.d = ref_out(longint'(bus.in_sum), longint'(bias_m[cnt_m]), longint'(scale),
                          int'(shift), relu_en);
            e.l = (cnt_m == 3);
            q.push_back(e);
            cnt_m = (cnt_m + 1) % 4;
            n_acc++;
        end
        if (bias_we) bias_m[bias_addr] = bias_data;
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bias_we       = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        repeat (4) cycle();
        check("drain_empty", q.size(), 0);
        #1 check("drain_out_valid", bus.out_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int a0, lat;
        scale = 16'(v.scl);
        shift = 5'(v.sh);
        relu_en = v.relu;
        bias_we = 1'b1;
        bias_addr = 2'(cnt_m);
        bias_data = v.bias;
        cycle();
        if (v.same) begin
            bias_addr = 2'(cnt_m);
            bias_data = v.bias + 99;
        end else begin
            bias_we = 1'b0;
        end
        a0 = n_acc;
        bus.in_valid = 1'b1;
        bus.in_sum = v.in_sum;
        cycle();
        bus.in_valid = 1'b0;
        bias_we = 1'b0;
        check($sformatf("vec%0d_accept", idx), n_acc - a0, 1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.out_valid) break;
            cycle();
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), lat, 3);
        check($sformatf("vec%0d_data", idx), longint'(bus.out_data), v.exp);
        cycle();
    endtask

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0;
        vecs[0] = '{100, -50, 1, 0, 0, 0, 50};
        vecs[1] = '{1, 2147483647, 1, 0, 0, 0, 127};
        vecs[2] = '{-1, -2147483647 - 1, 1, 0, 0, 0, -128};
        vecs[3] = '{0, -10, 1, 0, 1, 0, 0};
        vecs[4] = '{0, -10, 1, 0, 0, 0, -10};
`ifdef FC_REQUANT_ROUND_EN
        vecs[5] = '{0, 3, 1, 1, 0, 0, 2};
        vecs[6] = '{0, -3, 1, 1, 0, 0, -1};
        vecs[7] = '{0, 1000, 1, 4, 0, 0, 63};
`else
        vecs[5] = '{0, 3, 1, 1, 0, 0, 1};
        vecs[6] = '{0, -3, 1, 1, 0, 0, -2};
        vecs[7] = '{0, 1000, 1, 4, 0, 0, 62};
`endif
        vecs[8] = '{5, 20, 2, 0, 1, 0, 50};
        vecs[9] = '{7, 0, 1, 0, 0, 1, 7};

        rst = 1'b1;
        bias_we = 1'b0; bias_addr = '0; bias_data = '0;
        scale = 16'd1; shift = '0; relu_en = 1'b0;
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.out_ready = 1'b1;
        repeat (3) cycle();
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1 check("in_ready_after_rst", bus.in_ready, 1);

        for (int k = 0; k < 4; k++) begin
            bias_we = 1'b1; bias_addr = 2'(k); bias_data = k * 1000 - 1500;
            cycle();
        end
        bias_we = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
        drain();

        // Backpressure: only FIFO_DEPTH samples may be taken while the consumer stalls.
        scale = 16'd1; shift = 5'd0; relu_en = 1'b0;
        bus.out_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum = $signed(32'($urandom_range(0, 200))) - 100;
            cycle();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", n_acc - a0, 4);
        #1;
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        a0 = n_rd;
        drain();
        check("bp_released", n_rd - a0, 4);

        // out_last on every 4th output across a 9-sample stream.
        scale = 16'd1; shift = 5'd4;
        do_reset();
        last_pos.delete();
        n_rd = 0;
        a0 = n_acc;
        for (int i = 0; i < 200 && (n_acc - a0) < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum = $signed(32'($urandom_range(0, 2000))) - 1000;
            cycle();
        end
        bus.in_valid = 1'b0;
        drain();
        check("last_count", last_pos.size(), 2);
        if (last_pos.size() == 2) begin
            check("last_pos0", last_pos[0], 4);
            check("last_pos1", last_pos[1], 8);
        end

        // Reset mid-stream discards everything and restarts at neuron 0.
        do_reset();
        bus.out_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 200 && (n_acc - a0) < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum = $signed(32'($urandom_range(0, 2000))) - 1000;
            if (i == 4) bus.out_ready = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1 check("midrst_out_valid_during", bus.out_valid, 0);
        cycle();
        rst = 1'b0;
        #1;
        check("midrst_out_valid_after", bus.out_valid, 0);
        check("midrst_in_ready_after", bus.in_ready, 1);
        rd_log.delete();
        last_pos.delete();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sum = 32'sd321;
        cycle();
        bus.in_valid = 1'b0;
        drain();
        check("midrst_out_count", rd_log.size(), 1);
        if (rd_log.size() == 1)
            check("midrst_neuron0", rd_log[0], ref_out(321, longint'(bias_m[0]), 1, 4, 0));
        check("midrst_no_last", last_pos.size(), 0);

        // Randomized layers against the reference model.
        for (int seg = 0; seg < 4; seg++) begin
            drain();
            scale = (seg == 0) ? 16'($urandom_range(1, 4)) : 16'($urandom_range(0, 65535));
            shift = (seg == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
            relu_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 150; i++) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1)
                    bus.in_sum = $signed($urandom());
                else
                    bus.in_sum = $signed(32'($urandom_range(0, 4000))) - 2000;
                bus.out_ready = ($urandom_range(0, 2) != 0);
                bias_we = ($urandom_range(0, 7) == 0);
                bias_addr = 2'($urandom_range(0, 3));
                bias_data = $signed(32'($urandom_range(0, 20000))) - 10000;
                cycle();
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/fc_requant.md
FC_REQUANT -- requirements
Module: fc_requant

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 64, meaning outputs per FC layer; the bias table depth.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, >=4).
REQ-003 SHALL have port clk  input  1  clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_sum valid (from the PE_FC column output).
REQ-006 SHALL have port in_sum  input  32  signed accumulated dot product.
REQ-007 SHALL have port in_ready  output  1  block accepts in_sum this cycle.
REQ-008 SHALL have port bias_we  input  1  bias table write strobe.
REQ-009 SHALL have port bias_addr  input  $clog2(NUM_NEURONS)  bias write index.
REQ-010 SHALL have port bias_data  input  32  signed bias value.
REQ-011 SHALL have port scale  input  16  unsigned requant multiplier, static during a layer.
REQ-012 SHALL have port shift  input  5  right-shift amount 0..31, static during a layer.
REQ-013 SHALL have port relu_en  input  1  clamp negative results to 0.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_data  output  8  signed int8 activation.
REQ-016 SHALL have port out_last  output  1  marks the entry for neuron NUM_NEURONS-1.
REQ-017 SHALL have port out_ready  input  1  consumer accepts out_data.

Function
REQ-018 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output); no other condition.
REQ-019 Neuron counter SHALL increment per accepted input, wrap NUM_NEURONS-1 -> 0, and tag each sample with last = (count == NUM_NEURONS-1).
REQ-020 Stage 1 SHALL add bias[count] to in_sum in 33 bits, saturating to [-2^31, 2^31-1].
REQ-021 Stage 2 SHALL multiply the stage-1 result by zero-extended scale into a 48-bit signed product.
REQ-022 Stage 3 SHALL arithmetic-right-shift by shift, apply ReLU if relu_en, and saturate to [-128, 127].
REQ-023 Latency from input accept to FIFO write SHALL be exactly 3 cycles; stages SHALL advance unconditionally.
REQ-024 in_ready SHALL be 1 iff (FIFO occupancy + samples in stages 1-3) < FIFO_DEPTH; no sample is ever dropped.
REQ-025 out_valid SHALL equal FIFO non-empty; out_data/out_last SHALL come from the FIFO head and hold stable while out_valid&&!out_ready.
REQ-026 Simultaneous FIFO write and read SHALL keep occupancy unchanged, including when full or empty.
REQ-027 A bias write SHALL take effect for samples accepted on the following cycle or later; a same-cycle read of that address SHALL return the old value.

Reset
REQ-028 Under rst: out_valid=0, out_last=0, out_data=0, in_ready=0, FIFO empty, stages invalid, neuron counter 0.
REQ-029 in_ready SHALL be 1 the first cycle after rst deasserts; rst mid-stream SHALL discard in-flight and buffered samples.
REQ-030 Bias table SHALL NOT be cleared by rst; contents are undefined until written.

Configuration
REQ-031 With FC_REQUANT_ROUND_EN defined, stage 3 SHALL add 2^(shift-1) before shifting when shift>0 (round half up); without it, it SHALL truncate toward negative infinity.

Structure
REQ-032 Package fc_pkg SHALL hold acc_t (32-bit signed), act_t (8-bit signed), and the INT32/INT8 saturation limits shared with PE_FC.
REQ-033 The output buffer SHALL be a separate sub-module fc_out_fifo (synchronous, parameterised width/depth, full/empty/count).

Verification
REQ-034 bias[0]=100, in_sum=-50, scale=1, shift=0, relu_en=0 -> out_data=50, 3-cycle latency to out_valid.
REQ-035 bias[0]=1, in_sum=2147483647, scale=1, shift=0 -> out_data=127; in_sum=-2147483648, bias=-1 -> out_data=-128.
REQ-036 bias=0, in_sum=-10, scale=1, shift=0: relu_en=1 -> 0; relu_en=0 -> -10.
REQ-037 bias=0, scale=1, shift=1: in_sum=3 -> 2 with FC_REQUANT_ROUND_EN, 1 without; in_sum=-3 -> -1 with, -2 without.
REQ-038 FIFO_DEPTH=4, out_ready=0, in_valid=1 continuously -> exactly 4 accepted, in_ready=0 thereafter; release out_ready -> 4 outputs in order, none lost.
REQ-039 NUM_NEURONS=4, stream 9 inputs -> out_last on outputs 4 and 8; rst after input 6 -> out_valid=0 next cycle, next output is neuron 0.
